// File: rtl/gray_counter_param_pkg.sv
// Shared constants and types for the parametrised Gray counter.
package gray_counter_param_pkg;

    // Direction encodings for the dir input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // End-of-range behaviour selected by the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Winning action for one clock edge, after priority resolution
    // (reset is handled separately because it overrides everything).
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } action_t;

endpackage

// File: rtl/gray_counter_param_gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of
// every Gray bit at or above it.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_prefix_xor
            assign b[gi] = ^g[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_counter_param.sv
// Up/down Gray counter with load, clear, wrap/saturate mode, sticky
// overflow/underflow flags and a one-cycle terminal-count pulse.
module gray_counter_param
    import gray_counter_param_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SATURATE = MODE_WRAP,
    parameter int INIT     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] bin_count,
    output logic             overflow,
    output logic             underflow,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_B  = '1;
    localparam logic [WIDTH-1:0] ONE_B  = WIDTH'(1);
    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);

    logic [WIDTH-1:0] bin_reg, bin_next;
    logic [WIDTH-1:0] gray_reg;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    logic             tc_reg, tc_next;
    logic [WIDTH-1:0] load_bin;
    action_t          act;

    gray_to_bin #(.WIDTH(WIDTH)) u_load_decode (
        .g (load_gray),
        .b (load_bin)
    );

    // Resolve the per-edge priority: clear beats load beats count.
    always_comb begin
        act = ACT_HOLD;
        if (clear)
            act = ACT_CLEAR;
        else if (load)
            act = ACT_LOAD;
        else if (en)
            act = ACT_COUNT;
    end

    // Next binary state, sticky flags and terminal-count pulse.
    always_comb begin
        bin_next = bin_reg;
        ovf_next = ovf_reg;
        udf_next = udf_reg;
        tc_next  = 1'b0;
        case (act)
            ACT_CLEAR: begin
                bin_next = '0;
                ovf_next = 1'b0;
                udf_next = 1'b0;
            end
            ACT_LOAD: begin
                bin_next = load_bin;
            end
            ACT_COUNT: begin
                if (dir == DIR_UP) begin
                    if (bin_reg == MAX_B) begin
                        ovf_next = 1'b1;
                        tc_next  = 1'b1;
                        if (SATURATE == MODE_WRAP)
                            bin_next = '0;
                    end else begin
                        bin_next = bin_reg + ONE_B;
                    end
                end else begin
                    if (bin_reg == '0) begin
                        udf_next = 1'b1;
                        tc_next  = 1'b1;
                        if (SATURATE == MODE_WRAP)
                            bin_next = MAX_B;
                    end else begin
                        bin_next = bin_reg - ONE_B;
                    end
                end
            end
            default: begin
                bin_next = bin_reg;
            end
        endcase
    end

    // State registers; the Gray output is registered from the next binary
    // value so it changes on the same edge as bin_count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin_reg  <= INIT_B;
            gray_reg <= INIT_B ^ (INIT_B >> 1);
            ovf_reg  <= 1'b0;
            udf_reg  <= 1'b0;
            tc_reg   <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= bin_next ^ (bin_next >> 1);
            ovf_reg  <= ovf_next;
            udf_reg  <= udf_next;
            tc_reg   <= tc_next;
        end
    end

    assign gray_count = gray_reg;
    assign bin_count  = bin_reg;
    assign overflow   = ovf_reg;
    assign underflow  = udf_reg;
    assign tc         = tc_reg;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench: 3-bit wrap counter, 3-bit saturating counter and an
// 8-bit free-running counter, all driven from one initial block.
module tb_gray_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // 3-bit wrap instance
    logic       a_rst_n, a_en, a_dir, a_clr, a_ld;
    logic [2:0] a_ldg, a_gray, a_bin;
    logic       a_ovf, a_udf, a_tc;
    // 3-bit saturating instance
    logic       s_rst_n, s_en, s_dir, s_clr, s_ld;
    logic [2:0] s_ldg, s_gray, s_bin;
    logic       s_ovf, s_udf, s_tc;
    // 8-bit wrap instance
    logic       w_rst_n, w_en, w_dir, w_clr, w_ld;
    logic [7:0] w_ldg, w_gray, w_bin;
    logic       w_ovf, w_udf, w_tc;

    gray_counter_param #(.WIDTH(3), .SATURATE(0), .INIT(0)) u_wrap (
        .clk(clk), .reset_n(a_rst_n), .en(a_en), .dir(a_dir), .clear(a_clr),
        .load(a_ld), .load_gray(a_ldg), .gray_count(a_gray), .bin_count(a_bin),
        .overflow(a_ovf), .underflow(a_udf), .tc(a_tc));

    gray_counter_param #(.WIDTH(3), .SATURATE(1), .INIT(0)) u_sat (
        .clk(clk), .reset_n(s_rst_n), .en(s_en), .dir(s_dir), .clear(s_clr),
        .load(s_ld), .load_gray(s_ldg), .gray_count(s_gray), .bin_count(s_bin),
        .overflow(s_ovf), .underflow(s_udf), .tc(s_tc));

    gray_counter_param #(.WIDTH(8), .SATURATE(0), .INIT(0)) u_w8 (
        .clk(clk), .reset_n(w_rst_n), .en(w_en), .dir(w_dir), .clear(w_clr),
        .load(w_ld), .load_gray(w_ldg), .gray_count(w_gray), .bin_count(w_bin),
        .overflow(w_ovf), .underflow(w_udf), .tc(w_tc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check all outputs of the 3-bit wrap instance in one line.
    task automatic chk_a(input string tag, input logic [2:0] g, input logic [2:0] b,
                         input logic o, input logic u, input logic t);
        chk({tag, ".gray"}, 16'(a_gray), 16'(g));
        chk({tag, ".bin"},  16'(a_bin),  16'(b));
        chk({tag, ".ovf"},  16'(a_ovf),  16'(o));
        chk({tag, ".udf"},  16'(a_udf),  16'(u));
        chk({tag, ".tc"},   16'(a_tc),   16'(t));
        $display("%0t %s gray=%b bin=%0d ovf=%b udf=%b tc=%b", $time, tag, a_gray, a_bin, a_ovf, a_udf, a_tc);
    endtask

    task automatic chk_s(input string tag, input logic [2:0] g, input logic o,
                         input logic u, input logic t);
        chk({tag, ".gray"}, 16'(s_gray), 16'(g));
        chk({tag, ".ovf"},  16'(s_ovf),  16'(o));
        chk({tag, ".udf"},  16'(s_udf),  16'(u));
        chk({tag, ".tc"},   16'(s_tc),   16'(t));
        $display("%0t %s gray=%b bin=%0d ovf=%b udf=%b tc=%b", $time, tag, s_gray, s_bin, s_ovf, s_udf, s_tc);
    endtask

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Expected Gray codes for 3-bit up count from B=1..7 then wrap to 0.
    logic [2:0] up_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        logic [7:0] prev_gray;
        logic [7:0] diff;
        int         wraps;
        int         ones;

        a_rst_n = 0; a_en = 0; a_dir = 1; a_clr = 0; a_ld = 0; a_ldg = 0;
        s_rst_n = 0; s_en = 0; s_dir = 1; s_clr = 0; s_ld = 0; s_ldg = 0;
        w_rst_n = 0; w_en = 0; w_dir = 1; w_clr = 0; w_ld = 0; w_ldg = 0;
        tick();
        tick();
        chk_a("reset", 3'b000, 3'd0, 0, 0, 0);
        chk_s("sat_reset", 3'b000, 0, 0, 0);
        chk("w8_reset.gray", 16'(w_gray), 16'h0);

        // Count up through a full cycle including the wrap.
        a_rst_n = 1; a_en = 1; a_dir = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_a($sformatf("up%0d", i), up_gray[i], 3'((i + 1) % 8),
                  (i == 7) ? 1'b1 : 1'b0, 0, (i == 7) ? 1'b1 : 1'b0);
        end
        a_en = 0;
        tick();
        chk_a("hold_after_wrap", 3'b000, 3'd0, 1, 0, 0);

        // Clear, then step down through the wrap to MAX.
        a_clr = 1;
        tick();
        chk_a("clear", 3'b000, 3'd0, 0, 0, 0);
        a_clr = 0; a_en = 1; a_dir = 0;
        tick();
        chk_a("down_wrap", 3'b100, 3'd7, 0, 1, 1);
        tick();
        chk_a("down6", 3'b101, 3'd6, 0, 1, 0);
        tick();
        chk_a("down5", 3'b111, 3'd5, 0, 1, 0);
        tick();
        chk_a("down4", 3'b110, 3'd4, 0, 1, 0);

        // Load wins over enable; sticky underflow untouched.
        a_ld = 1; a_ldg = 3'b011; a_dir = 1;
        tick();
        chk_a("load_over_en", 3'b011, 3'd2, 0, 1, 0);

        // Load B=5 (Gray 111), then assert reset together with en and load.
        a_ldg = 3'b111;
        tick();
        chk_a("load5", 3'b111, 3'd5, 0, 1, 0);
        a_rst_n = 0;
        tick();
        chk_a("reset_mid", 3'b000, 3'd0, 0, 0, 0);
        a_rst_n = 1; a_ld = 0;
        tick();
        chk_a("resume", 3'b001, 3'd1, 0, 0, 0);
        a_en = 0;

        // Saturating instance: load B=6 and push against MAX.
        s_rst_n = 1; s_ld = 1; s_ldg = 3'b101;
        tick();
        chk_s("sat_load6", 3'b101, 0, 0, 0);
        s_ld = 0; s_en = 1; s_dir = 1;
        tick();
        chk_s("sat_up7", 3'b100, 0, 0, 0);
        tick();
        chk_s("sat_hold1", 3'b100, 1, 0, 1);
        tick();
        chk_s("sat_hold2", 3'b100, 1, 0, 1);
        s_en = 0;
        tick();
        chk_s("sat_idle", 3'b100, 1, 0, 0);
        s_clr = 1;
        tick();
        chk_s("sat_clear", 3'b000, 0, 0, 0);
        s_clr = 0; s_en = 1; s_dir = 0;
        tick();
        chk_s("sat_down0", 3'b000, 0, 1, 1);
        s_en = 0;

        // 8-bit free run: single-bit steps, binary consistency, two wraps.
        w_rst_n = 1; w_en = 1; w_dir = 1;
        prev_gray = w_gray;
        wraps = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            diff = w_gray ^ prev_gray;
            ones = $countones(diff);
            chk($sformatf("w8_onebit%0d", i), 16'(ones), 16'd1);
            chk($sformatf("w8_bin%0d", i), 16'(w_bin), 16'(g2b8(w_gray)));
            chk($sformatf("w8_cnt%0d", i), 16'(w_bin), 16'((i + 1) % 256));
            if (w_tc) wraps++;
            prev_gray = w_gray;
        end
        chk("w8_wraps", 16'(wraps), 16'd2);
        $display("%0t w8 free run done wraps=%0d ovf=%b", $time, wraps, w_ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
